// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the arbitrated mux
package mux_pkg;

    localparam int MUX_MODE_FIXED = 0;
    localparam int MUX_MODE_RR    = 1;

    // Minimum index width for n channels; never below 1 so a 2-input mux still has a select bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational winner pick, round-robin from ptr+1 or lowest-index-first
module rr_pick
    import mux_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              rr_mode,
    output logic [NUM_IN-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any
);

    localparam logic [SEL_W:0] N_W = (SEL_W+1)'(NUM_IN);

    logic [SEL_W:0] cand;

    // One spare bit on cand lets ptr+1+k exceed NUM_IN-1 before a single wrap subtract.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (rr_mode) begin
                cand = {1'b0, ptr} + (SEL_W+1)'(k + 1);
            end else begin
                cand = (SEL_W+1)'(k);
            end
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!any && req[cand[SEL_W-1:0]]) begin
                any                     = 1'b1;
                gnt[cand[SEL_W-1:0]]    = 1'b1;
                gnt_idx                 = cand[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-input handshaked mux with built-in arbitration and one output register
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_IN  = 4,
    parameter  int RR_MODE = 1,
    localparam int SEL_W   = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    input  logic                    out_ready
);

    logic [SEL_W-1:0]  ptr;
    logic              load_en;
    logic [NUM_IN-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any;
    logic [WIDTH-1:0]  sel_data;

    rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .rr_mode (RR_MODE == MUX_MODE_RR),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign load_en  = !out_valid || out_ready;
    // Gated by rst_n so no source believes it was accepted while the register is held in reset.
    assign in_ready = (load_en && rst_n) ? gnt : '0;
    assign sel_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SEL_W'(NUM_IN - 1);
        end else if (load_en) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= gnt_idx;
                if (RR_MODE == MUX_MODE_RR) begin
                    ptr <= gnt_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - scenario and randomized checks of rr_arb_mux against a behavioural model
module tb_rr_arb_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  vld [3];
    logic [31:0] dat [3][4];
    logic        ordy [3];

    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2;
    logic        ov0, ov1, ov2;
    logic [31:0] od0, od1, od2;
    logic [1:0]  os0, os1, os2;

    int total = 0;
    int bad   = 0;

    int          n_of  [3] = '{4, 4, 3};
    bit          rr_of [3] = '{1'b1, 1'b0, 1'b1};
    int          m_ptr [3];
    bit          m_ov  [3];
    logic [31:0] m_od  [3];
    int          m_os  [3];

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(32), .NUM_IN(4), .RR_MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]),
        .in_data({dat[0][3], dat[0][2], dat[0][1], dat[0][0]}),
        .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_src(os0), .out_ready(ordy[0]));

    rr_arb_mux #(.WIDTH(32), .NUM_IN(4), .RR_MODE(0)) u_fp4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]),
        .in_data({dat[1][3], dat[1][2], dat[1][1], dat[1][0]}),
        .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_src(os1), .out_ready(ordy[1]));

    rr_arb_mux #(.WIDTH(32), .NUM_IN(3), .RR_MODE(1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2][2:0]),
        .in_data({dat[2][2], dat[2][1], dat[2][0]}),
        .in_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_src(os2), .out_ready(ordy[2]));

    function automatic logic [3:0] get_rdy(int i);
        case (i)
            0:       return rdy0;
            1:       return rdy1;
            default: return {1'b0, rdy2};
        endcase
    endfunction

    function automatic logic get_ov(int i);
        case (i)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic [31:0] get_od(int i);
        case (i)
            0:       return od0;
            1:       return od1;
            default: return od2;
        endcase
    endfunction

    function automatic int get_os(int i);
        case (i)
            0:       return int'(os0);
            1:       return int'(os1);
            default: return int'(os2);
        endcase
    endfunction

    // Reference rule: scan n channels starting after p (round-robin) or from 0 (fixed).
    function automatic int pick(logic [3:0] v, int p, int n, bit rr);
        for (int k = 0; k < n; k++) begin
            int c;
            c = rr ? (p + 1 + k) % n : k;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic reset_all();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld[i]  = 4'b0;
            ordy[i] = 1'b0;
            for (int c = 0; c < 4; c++) dat[i][c] = 32'h0;
            m_ptr[i] = n_of[i] - 1;
            m_ov[i]  = 1'b0;
            m_od[i]  = 32'h0;
            m_os[i]  = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld[i]  = 4'b0;
            ordy[i] = 1'b1;
            for (int c = 0; c < 4; c++) dat[i][c] = 32'h0;
        end
        vld[0] = 4'hF;
        #2;
        total++; if (rdy0 !== 4'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", rdy0); end
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
        total++; if (od0 !== 32'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", od0); end
        total++; if (os0 !== 2'd0) begin bad++; $display("FAIL reset_out_src: got %0d want 0", os0); end
        reset_all();
    endtask

    task automatic test_single();
        reset_all();
        vld[0] = 4'b0100; dat[0][2] = 32'hDEADBEEF; ordy[0] = 1'b1;
        #1;
        total++; if (rdy0 !== 4'b0100) begin bad++; $display("FAIL single_in_ready: got %b want 0100", rdy0); end
        @(posedge clk); #1;
        vld[0] = 4'b0;
        total++; if (ov0 !== 1'b1 || od0 !== 32'hDEADBEEF || os0 !== 2'd2) begin
            bad++; $display("FAIL single_out: got v=%b d=%h s=%0d want v=1 d=deadbeef s=2", ov0, od0, os0);
        end
    endtask

    task automatic test_fairness();
        reset_all();
        vld[0] = 4'hF; ordy[0] = 1'b1;
        for (int c = 0; c < 4; c++) dat[0][c] = 32'h10 + c;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            total++; if (ov0 !== 1'b1 || int'(os0) != k % 4 || od0 !== 32'h10 + (k % 4)) begin
                bad++; $display("FAIL rr_fair[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d", k, ov0, os0, od0, k % 4);
            end
        end
        vld[0] = 4'b0;
    endtask

    task automatic test_fixed();
        reset_all();
        vld[1] = 4'b1010; dat[1][1] = 32'h111; dat[1][3] = 32'h333; ordy[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (rdy1 !== 4'b0010) begin bad++; $display("FAIL fixed_ready[%0d]: got %b want 0010", k, rdy1); end
            @(posedge clk); #1;
            total++; if (ov1 !== 1'b1 || os1 !== 2'd1 || od1 !== 32'h111) begin
                bad++; $display("FAIL fixed_out[%0d]: got v=%b s=%0d d=%h want v=1 s=1 d=111", k, ov1, os1, od1);
            end
        end
        vld[1] = 4'b0;
    endtask

    task automatic test_backpressure();
        reset_all();
        vld[0] = 4'b0001; dat[0][0] = 32'hA5A5A5A5; ordy[0] = 1'b1;
        @(posedge clk); #1;
        total++; if (ov0 !== 1'b1 || od0 !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL bp_load: got v=%b d=%h want v=1 d=a5a5a5a5", ov0, od0);
        end
        ordy[0] = 1'b0; dat[0][0] = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (rdy0 !== 4'b0) begin bad++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", k, rdy0); end
            @(posedge clk); #1;
            total++; if (ov0 !== 1'b1 || od0 !== 32'hA5A5A5A5 || os0 !== 2'd0) begin
                bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d want v=1 d=a5a5a5a5 s=0", k, ov0, od0, os0);
            end
        end
        ordy[0] = 1'b1;
        #1;
        total++; if (rdy0 !== 4'b0001) begin bad++; $display("FAIL bp_release_ready: got %b want 0001", rdy0); end
        @(posedge clk); #1;
        vld[0] = 4'b0;
        total++; if (ov0 !== 1'b1 || od0 !== 32'h12345678) begin
            bad++; $display("FAIL bp_next: got v=%b d=%h want v=1 d=12345678", ov0, od0);
        end
    endtask

    task automatic test_wrap3();
        reset_all();
        vld[2] = 4'b0111; ordy[2] = 1'b1;
        for (int c = 0; c < 3; c++) dat[2][c] = 32'h300 + c;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total++; if (ov2 !== 1'b1 || int'(os2) != k % 3 || os2 === 2'd3) begin
                bad++; $display("FAIL wrap3[%0d]: got v=%b s=%0d want v=1 s=%0d", k, ov2, os2, k % 3);
            end
        end
        vld[2] = 4'b0;
    endtask

    task automatic test_async_reset();
        reset_all();
        vld[0] = 4'b0100; dat[0][2] = 32'hCAFE0002; ordy[0] = 1'b0;
        @(posedge clk); #1;
        vld[0] = 4'b0;
        @(posedge clk); #1;
        total++; if (ov0 !== 1'b1 || od0 !== 32'hCAFE0002) begin
            bad++; $display("FAIL ar_stall: got v=%b d=%h want v=1 d=cafe0002", ov0, od0);
        end
        vld[0] = 4'hF;
        for (int c = 0; c < 4; c++) dat[0][c] = 32'h40 + c;
        rst_n = 1'b0;
        #1;
        total++; if (ov0 !== 1'b0 || od0 !== 32'h0 || os0 !== 2'd0 || rdy0 !== 4'b0) begin
            bad++; $display("FAIL ar_async: got v=%b d=%h s=%0d r=%b want v=0 d=0 s=0 r=0000", ov0, od0, os0, rdy0);
        end
        #1 rst_n = 1'b1; ordy[0] = 1'b1;
        #1;
        total++; if (rdy0 !== 4'b0001) begin bad++; $display("FAIL ar_first_ready: got %b want 0001", rdy0); end
        @(posedge clk); #1;
        total++; if (ov0 !== 1'b1 || os0 !== 2'd0 || od0 !== 32'h40) begin
            bad++; $display("FAIL ar_first_out: got v=%b s=%0d d=%h want v=1 s=0 d=40", ov0, os0, od0);
        end
        vld[0] = 4'b0;
    endtask

    task automatic test_random(int inst, int cycles);
        reset_all();
        for (int t = 0; t < cycles; t++) begin
            int          w;
            bit          le;
            logic [3:0]  exp_rdy;
            for (int c = 0; c < n_of[inst]; c++) begin
                if (!vld[inst][c] && $urandom_range(0, 1) == 1) begin
                    vld[inst][c] = 1'b1;
                    dat[inst][c] = $urandom;
                end
            end
            ordy[inst] = ($urandom_range(0, 3) != 0);
            #1;
            le      = !m_ov[inst] || ordy[inst];
            w       = le ? pick(vld[inst], m_ptr[inst], n_of[inst], rr_of[inst]) : -1;
            exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
            total++; if (get_rdy(inst) !== exp_rdy) begin
                bad++; $display("FAIL rand%0d_ready[%0d]: got %b want %b", inst, t, get_rdy(inst), exp_rdy);
            end
            @(posedge clk); #1;
            if (le) begin
                if (w >= 0) begin
                    m_ov[inst] = 1'b1;
                    m_od[inst] = dat[inst][w];
                    m_os[inst] = w;
                    if (rr_of[inst]) m_ptr[inst] = w;
                    vld[inst][w] = 1'b0;
                end else begin
                    m_ov[inst] = 1'b0;
                end
            end
            total++; if (get_ov(inst) !== m_ov[inst] || get_od(inst) !== m_od[inst] || get_os(inst) != m_os[inst]) begin
                bad++; $display("FAIL rand%0d_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", inst, t,
                                get_ov(inst), get_od(inst), get_os(inst), m_ov[inst], m_od[inst], m_os[inst]);
            end
        end
        vld[inst] = 4'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_fixed();
        test_backpressure();
        test_wrap3();
        test_async_reset();
        test_random(0, 400);
        test_random(1, 400);
        test_random(2, 400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-input, registered, handshaked multiplexer with built-in arbitration; the successor of the plain 2:1 datapath select. Datapath sources compete for one shared consumer, such as the memory port or the writeback bus, without a separate arbiter. Each source offers a valid/ready stream. The block picks one per cycle, round-robin or fixed-priority, and presents it through a single output register stage.

## Interface
- `WIDTH`, 32: data width per channel, ≥1.
- `NUM_IN`, 4: number of input channels, ≥2.
- `RR_MODE`, 1: 1 = round-robin; 0 = fixed priority, lowest index wins.
- `SEL_W`, `clog2(NUM_IN)`: derived, not overridden.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  NUM_IN  per-channel request.
- `in_data`  in  NUM_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- `in_ready`  out  NUM_IN  one-hot or zero; channel i accepted this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  registered selected word.
- `out_src`  out  SEL_W  index of the channel that supplied `out_data`.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- `load_en = !out_valid || out_ready`.
- Winner selection, when `load_en` and any `in_valid`:
  - RR_MODE=1: search starts at `ptr+1` and wraps modulo NUM_IN. The first valid channel wins.
  - RR_MODE=0: the lowest valid index wins.
- `in_ready[w] = 1` for the winner only. All other `in_ready` bits are 0. `in_ready` never depends on `in_data`.
- On accept (posedge after `in_valid[w] && in_ready[w]`):
  - `out_data <= in_data[w]`, `out_src <= w`, `out_valid <= 1`.
  - In RR mode, `ptr <= w`.
- If `load_en` and no `in_valid`: `out_valid <= 0`. `out_data` and `out_src` hold their last values.
- If `out_valid && !out_ready` (stall): all `in_ready` are 0 and `out_data`, `out_src`, `out_valid` and `ptr` hold.
- Simultaneous drain and refill (`out_valid && out_ready` with a valid input): the new word loads in the same edge. Full throughput is one word per cycle.
- `ptr` changes only on accept. It is not advanced by idle cycles or by a channel dropping `in_valid`.
- `ptr` range is 0..NUM_IN-1. Wrap-around from NUM_IN-1 goes to 0. For non-power-of-two NUM_IN, indices ≥ NUM_IN are never selected or stored.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `ptr=NUM_IN-1`, so channel 0 has first priority after reset. `in_ready=0` while `rst_n=0`.
- Reset mid-transfer: the held word is discarded and the state above applies immediately, asynchronously. Deassertion is synchronised externally; the block needs no extra handling.
- Latency: 1 cycle from input accept to `out_valid`.
- Combinational paths:
  - `in_valid` and `out_ready` → `in_ready` only.
  - No path from `in_*` to `out_valid`, `out_data` or `out_src`.
- Sources must keep `in_valid` and `in_data` stable until accepted. The block does not check this.

## Structure
- Shared package `mux_pkg` holds:
  - the `clog2` function used for `SEL_W`;
  - mode constants `MUX_MODE_FIXED=0` and `MUX_MODE_RR=1`.
- Sub-module `rr_pick` is purely combinational:
  - inputs: `req[NUM_IN]`, `ptr[SEL_W]`, `rr_mode`;
  - outputs: `gnt` (one-hot), `gnt_idx`, `any`.
- The top level holds only `ptr`, the output register and the handshake logic.

## Test plan
- Reset/single channel: NUM_IN=4, WIDTH=32. After reset, only ch2 is valid with `0xDEADBEEF` and `out_ready=1`. Required: `in_ready=4'b0100`. Next cycle `out_valid=1`, `out_data=0xDEADBEEF`, `out_src=2`.
- Round-robin fairness: all four channels held valid with data `0x10`..`0x13` and `out_ready=1`. Required: `out_src` sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Fixed priority: RR_MODE=0, ch1 and ch3 valid continuously. Required: `out_src=1` every cycle and ch3 is never granted.
- Backpressure: output holds `0xA5A5A5A5` and `out_ready=0` for 3 cycles while ch0 is valid. Required: `in_ready=0`, `out_data` and `out_src` unchanged. On the cycle `out_ready=1`, ch0 is accepted and the next word appears one cycle later.
- Non-power-of-two wrap: NUM_IN=3, all valid. Required: sequence 0,1,2,0, and `out_src` never equals 3.
- Async reset mid-stall: `out_valid=1` held under stall, `rst_n` pulsed low between clock edges. Required: `out_valid=0` and `out_data=0` before the next edge. After release, ch0 is granted first when all are valid.
